// File: rtl/rvfi_check_sequencer.sv
// Stimulus sequencer for single-instruction RVFI checkers: holds the DUT in reset,
// picks a trigger retirement inside a cycle window, and emits check a fixed delay later.
module rvfi_check_sequencer #(
    parameter int NRET         = 1,
    parameter int CHANNEL_IDX  = 0,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_MIN     = 2,
    parameter int TRIG_MAX     = 10,
    parameter int CHECK_DELAY  = 5,
    parameter int CNT_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRET-1:0]     rvfi_valid,
    input  logic [64*NRET-1:0]  rvfi_order,
    input  logic                rvfi_rollback_valid,
    input  logic [63:0]         rvfi_rollback_order,
    output logic                dut_reset,
    output logic                trig,
    output logic                check,
    output logic [63:0]         trig_order,
    output logic [CNT_W-1:0]    cycle,
    output logic                vacuous,
    output logic                done
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMIN     = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] TMAX     = CNT_W'(TRIG_MAX);
    localparam logic [CNT_W-1:0] DLY      = CNT_W'(CHECK_DELAY);

    typedef enum logic [2:0] {RST, ARM, WAIT, CHECK, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  delay_cnt;
    logic              chan_valid;
    logic [63:0]       chan_order;
    logic              in_window;
    logic              kill;

    assign chan_valid = rvfi_valid[CHANNEL_IDX];
    assign chan_order = rvfi_order[64*CHANNEL_IDX +: 64];
    assign in_window  = (cycle >= TMIN) && (cycle <= TMAX);
    assign kill       = rvfi_rollback_valid && (rvfi_rollback_order <= trig_order)
                        && ((state == WAIT) || (state == CHECK));

    always_ff @(posedge clock) begin
        if (reset) state <= RST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RST:   if (cycle == RST_LAST) state_next = ARM;
            ARM: begin
                if (trig)                state_next = (CHECK_DELAY == 1) ? CHECK : WAIT;
                else if (cycle >= TMAX)  state_next = DONE;
            end
            // Counter is loaded with CHECK_DELAY in the trig cycle; leaving WAIT when
            // the post-decrement value reaches 1 lands CHECK exactly CHECK_DELAY cycles later.
            WAIT: begin
                if (kill)                         state_next = (cycle < TMAX) ? ARM : DONE;
                else if (delay_cnt == CNT_W'(2))  state_next = CHECK;
            end
            CHECK: begin
                if (kill) state_next = (cycle < TMAX) ? ARM : DONE;
                else      state_next = DONE;
            end
            DONE:  state_next = DONE;
            default: state_next = RST;
        endcase
    end

    always_comb begin
        dut_reset = (state == RST);
        trig      = (state == ARM) && chan_valid && in_window;
        check     = (state == CHECK) && !kill;
        done      = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle      <= '0;
            delay_cnt  <= '0;
            trig_order <= '0;
            vacuous    <= 1'b0;
        end else begin
            if (cycle != '1) cycle <= cycle + CNT_W'(1);
            if (trig) begin
                trig_order <= chan_order;
                delay_cnt  <= DLY;
            end else if (state == WAIT) begin
                delay_cnt <= delay_cnt - CNT_W'(1);
            end
            if (((state == ARM) && !trig && (cycle >= TMAX)) || (kill && (cycle >= TMAX)))
                vacuous <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Scoreboard bench for rvfi_check_sequencer: directed scenarios queue expected trig/check
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_rvfi_check_sequencer;

    localparam int NRET         = 1;
    localparam int RESET_CYCLES = 1;
    localparam int CNT_W        = 16;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NRET-1:0]    rvfi_valid = '0;
    logic [64*NRET-1:0] rvfi_order = '0;
    logic               rvfi_rollback_valid = 1'b0;
    logic [63:0]        rvfi_rollback_order = '0;
    logic               dut_reset;
    logic               trig;
    logic               check;
    logic [63:0]        trig_order;
    logic [CNT_W-1:0]   cycle;
    logic               vacuous;
    logic               done;

    always #5 clock = ~clock;

    rvfi_check_sequencer #(
        .NRET(NRET), .CHANNEL_IDX(0), .RESET_CYCLES(RESET_CYCLES), .TRIG_MIN(2),
        .TRIG_MAX(10), .CHECK_DELAY(5), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_rollback_valid(rvfi_rollback_valid), .rvfi_rollback_order(rvfi_rollback_order),
        .dut_reset(dut_reset), .trig(trig), .check(check), .trig_order(trig_order),
        .cycle(cycle), .vacuous(vacuous), .done(done)
    );

    typedef struct {
        int unsigned cyc;
        logic [63:0] order;
    } trig_t;

    trig_t       exp_trig[$];
    int unsigned exp_check[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned tb_cyc = 0;
    logic        seen_reset = 1'b0;
    logic        order_pending = 1'b0;
    logic [63:0] order_exp = '0;

    always @(posedge clock) begin
        if (reset) begin
            tb_cyc     <= 0;
            seen_reset <= 1'b1;
        end else begin
            tb_cyc <= tb_cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, tb_cyc);
    endtask

    // Monitor: compares every trig/check pulse against the scoreboard queues.
    always @(negedge clock) begin
        if (seen_reset && !reset) begin
            chk("cycle", 64'(cycle), 64'(tb_cyc));
            chk("dut_reset", 64'(dut_reset), 64'(tb_cyc < RESET_CYCLES));
            chk("trig_check_exclusive", 64'(trig & check), 64'd0);
            if (order_pending) begin
                chk("trig_order", trig_order, order_exp);
                order_pending = 1'b0;
            end
            if (trig) begin
                if (exp_trig.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_trig: trig=1 at cycle %0d, required 0", tb_cyc);
                end else begin
                    trig_t t;
                    t = exp_trig.pop_front();
                    chk("trig_cycle", 64'(tb_cyc), 64'(t.cyc));
                    order_exp     = t.order;
                    order_pending = 1'b1;
                end
            end
            if (check) begin
                if (exp_check.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_check: check=1 at cycle %0d, required 0", tb_cyc);
                end else begin
                    int unsigned c;
                    c = exp_check.pop_front();
                    chk("check_cycle", 64'(tb_cyc), 64'(c));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] o, input logic rbv, input logic [63:0] rbo);
        rvfi_valid[0]       = v;
        rvfi_order[63:0]    = o;
        rvfi_rollback_valid = rbv;
        rvfi_rollback_order = rbo;
    endtask

    task automatic do_reset;
        drive(1'b0, 64'd0, 1'b0, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_trig(input int unsigned c, input logic [63:0] o);
        trig_t t;
        t.cyc   = c;
        t.order = o;
        exp_trig.push_back(t);
    endtask

    task automatic sb_drain(input string tag);
        chk({tag, "_missing_trig"}, 64'(exp_trig.size()), 64'd0);
        chk({tag, "_missing_check"}, 64'(exp_check.size()), 64'd0);
        exp_trig.delete();
        exp_check.delete();
    endtask

    initial begin
        logic [63:0] ord4;
        ord4 = 64'hDEAD_BEEF_0000_0004;

        // Plain run: valid every cycle with order = cycle index.
        push_trig(2, 64'd2);
        exp_check.push_back(7);
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            drive(1'b1, 64'(k), 1'b0, 64'd0);
            @(negedge clock);
            if (k == 0) begin
                chk("reset_trig", 64'(trig), 64'd0);
                chk("reset_check", 64'(check), 64'd0);
                chk("reset_done", 64'(done), 64'd0);
                chk("reset_vacuous", 64'(vacuous), 64'd0);
                chk("reset_trig_order", trig_order, 64'd0);
            end
            if (k == 7) chk("plain_not_done_at_check", 64'(done), 64'd0);
            if (k >= 8) chk("plain_done", 64'(done), 64'd1);
            tick();
        end
        sb_drain("plain");
        chk("plain_vacuous", 64'(vacuous), 64'd0);

        // Window miss: no retirements at all.
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 0) chk("miss_trig_order_cleared", trig_order, 64'd0);
            if (k == 10) begin
                chk("miss_done_c10", 64'(done), 64'd0);
                chk("miss_vacuous_c10", 64'(vacuous), 64'd0);
            end
            if (k == 11) begin
                chk("miss_done_c11", 64'(done), 64'd1);
                chk("miss_vacuous_c11", 64'(vacuous), 64'd1);
            end
            tick();
        end
        sb_drain("miss");

        // Early valid at cycle 1 ignored; valid at cycle 4 triggers.
        push_trig(4, ord4);
        exp_check.push_back(9);
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k == 1)      drive(1'b1, 64'd1, 1'b0, 64'd0);
            else if (k == 4) drive(1'b1, ord4, 1'b0, 64'd0);
            else             drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 12) chk("early_done", 64'(done), 64'd1);
            tick();
        end
        sb_drain("early");
        chk("early_vacuous", 64'(vacuous), 64'd0);

        // Rollback in WAIT (with a simultaneous retirement) re-arms.
        push_trig(3, 64'd3);
        push_trig(6, 64'd2);
        exp_check.push_back(11);
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            if (k == 3)      drive(1'b1, 64'd3, 1'b0, 64'd0);
            else if (k == 5) drive(1'b1, 64'd7, 1'b1, 64'd2);
            else if (k == 6) drive(1'b1, 64'd2, 1'b0, 64'd0);
            else             drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 6) chk("rearm_order_kept", trig_order, 64'd3);
            if (k == 14) chk("rearm_vacuous", 64'(vacuous), 64'd0);
            tick();
        end
        sb_drain("rearm");

        // Rollback with a younger order is ignored; rollback in DONE is ignored.
        push_trig(3, 64'd3);
        exp_check.push_back(8);
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k == 3)      drive(1'b1, 64'd3, 1'b0, 64'd0);
            else if (k == 5) drive(1'b0, 64'd0, 1'b1, 64'd4);
            else if (k == 9) drive(1'b1, 64'd9, 1'b1, 64'd0);
            else             drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 10) begin
                chk("ignore_done", 64'(done), 64'd1);
                chk("ignore_vacuous", 64'(vacuous), 64'd0);
            end
            tick();
        end
        sb_drain("ignore");

        // Rollback in the check cycle suppresses check and re-arms.
        push_trig(3, 64'd3);
        push_trig(9, 64'd5);
        exp_check.push_back(14);
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            if (k == 3)      drive(1'b1, 64'd3, 1'b0, 64'd0);
            else if (k == 8) drive(1'b0, 64'd0, 1'b1, 64'd0);
            else if (k == 9) drive(1'b1, 64'd5, 1'b0, 64'd0);
            else             drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 8) chk("chkkill_check_low", 64'(check), 64'd0);
            if (k == 16) chk("chkkill_vacuous", 64'(vacuous), 64'd0);
            tick();
        end
        sb_drain("chkkill");

        // Trig at the last window cycle killed after the window: vacuous finish.
        push_trig(10, 64'd10);
        do_reset();
        for (int k = 0; k <= 16; k++) begin
            if (k == 10)      drive(1'b1, 64'd10, 1'b0, 64'd0);
            else if (k == 12) drive(1'b0, 64'd0, 1'b1, 64'd10);
            else              drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 12) chk("late_vacuous_c12", 64'(vacuous), 64'd0);
            if (k == 13) begin
                chk("late_done", 64'(done), 64'd1);
                chk("late_vacuous", 64'(vacuous), 64'd1);
            end
            tick();
        end
        sb_drain("late");

        // Mid-run reset in WAIT drops the pending check.
        push_trig(2, 64'd2);
        do_reset();
        for (int k = 0; k <= 3; k++) begin
            drive(1'b1, 64'(k), 1'b0, 64'd0);
            @(negedge clock);
            tick();
        end
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            drive(1'b0, 64'd0, 1'b0, 64'd0);
            @(negedge clock);
            if (k == 0) begin
                chk("midreset_cycle", 64'(cycle), 64'd0);
                chk("midreset_dut_reset", 64'(dut_reset), 64'd1);
            end
            if (k == 9) chk("midreset_done", 64'(done), 64'd0);
            tick();
        end
        sb_drain("midreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rvfi_check_sequencer.md
Name: rvfi_check_sequencer

Overview:
- Upstream stimulus generator for the single-instruction RVFI checkers (uniqueness, ordering, instruction checks).
- Holds the DUT in reset for a fixed number of cycles, then picks the trigger cycle: the first retirement on the selected channel inside a cycle window.
- Emits a checker `trig` pulse in that same cycle and a `check` pulse a fixed delay later.
- Re-arms when a rollback kills the triggered instruction.

Parameters:
NRET, 1, number of RVFI retire channels
CHANNEL_IDX, 0, channel on which trig is generated (0..NRET-1)
RESET_CYCLES, 1, cycles dut_reset is held high after reset (>=1)
TRIG_MIN, 2, earliest cycle index at which trig may fire
TRIG_MAX, 10, latest cycle index at which trig may fire (>=TRIG_MIN>=RESET_CYCLES)
CHECK_DELAY, 5, cycles from trig to check (>=1)
CNT_W, 16, width of cycle and delay counters

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rvfi_valid  input  NRET  per-channel retire valid
rvfi_order  input  64*NRET  per-channel instruction order, channel i at [64*i +: 64]
rvfi_rollback_valid  input  1  rollback event this cycle
rvfi_rollback_order  input  64  first order invalidated by the rollback
dut_reset  output  1  reset to DUT and checker
trig  output  1  trigger to checker (combinational, same cycle as retirement)
check  output  1  check strobe to checker (registered state decode)
trig_order  output  64  order captured at last trig
cycle  output  CNT_W  cycles since reset release, saturating at all-ones
vacuous  output  1  window closed without a surviving trigger
done  output  1  sequence finished

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - State goes to RST; cycle=0, delay counter=0, trig_order=0, vacuous=0.
  - In the cycle after reset deasserts: dut_reset=1, trig=0, check=0, done=0.
- cycle:
  - Increments by 1 every non-reset cycle and saturates at 2^CNT_W-1.
  - Cycle index k means the k-th cycle after reset release, starting at 0.
- States: RST, ARM, WAIT, CHECK, DONE. Encoding is free.
- RST:
  - dut_reset=1.
  - Go to ARM when cycle==RESET_CYCLES-1.
  - dut_reset is high for exactly cycles 0..RESET_CYCLES-1.
- ARM:
  - trig = rvfi_valid[CHANNEL_IDX] && TRIG_MIN<=cycle<=TRIG_MAX.
  - On trig:
    - trig_order <= rvfi_order[64*CHANNEL_IDX +: 64].
    - delay counter <= CHECK_DELAY.
    - Next state WAIT.
  - If no trig and cycle>=TRIG_MAX: next state DONE, vacuous<=1.
  - Other channels' valids never cause trig.
- WAIT:
  - Delay counter decrements each cycle.
  - Go to CHECK when the counter equals 1. CHECK_DELAY==1 therefore goes straight to CHECK.
  - check is high exactly in cycle T+CHECK_DELAY, where T is the trig cycle.
- CHECK: check=1 for one cycle; next state DONE.
- DONE: terminal until reset. done=1; trig=0; check=0.
- Rollback:
  - A rollback kills the trigger when rvfi_rollback_valid && rvfi_rollback_order<=trig_order, in WAIT or CHECK. Rollback has priority over check.
  - In CHECK, check is forced to 0 that cycle.
  - Next state is ARM if cycle<TRIG_MAX; otherwise DONE with vacuous=1.
  - trig_order keeps its old value until the next trig.
  - No trig can occur in the rollback cycle itself.
  - A rollback with rvfi_rollback_order>trig_order is ignored.
  - Rollbacks in RST, ARM or DONE are ignored.
- Simultaneous events:
  - Rollback and retirement in the same WAIT cycle: the retirement is not considered. Re-arming takes effect the next cycle.
  - Reset at any time overrides everything and restarts from RST. Any pending check is dropped.
- Output invariants:
  - trig is high for at most one cycle per arm.
  - check never asserts without a preceding trig in the same arm.
  - check and trig are never high in the same cycle.
- Counter and order widths:
  - The delay counter is CNT_W bits wide.
  - order comparisons are 64-bit unsigned.

Test Plan:
- Plain run: RESET_CYCLES=1, TRIG_MIN=2, CHECK_DELAY=5; valid[0] high from cycle 0 with order=cycle → dut_reset high in cycle 0 only; trig in cycle 2, trig_order=2; check in cycle 7; done from cycle 8; vacuous=0.
- Window miss: valid never high, TRIG_MAX=10 → trig never asserts; DONE entered at cycle 11; vacuous=1; check never asserts.
- Early valid: valid[0] only at cycles 1 and 4, TRIG_MIN=2 → no trig at cycle 1; trig at cycle 4; check at cycle 9.
- Rollback re-arm: trig at cycle 3 with order 3; rollback at cycle 5 with rollback_order=2 → no check at cycle 8; ARM at cycle 6; next valid at cycle 6 with order 2 → trig at cycle 6, trig_order=2; check at cycle 11.
- Rollback ignored, then rollback in CHECK: rollback_order=9 with trig_order=3 → check unaffected. Rollback_order=0 in the check cycle → check=0 and re-arm.
- Mid-run reset: reset asserted in WAIT → next cycle RST, cycle=0, dut_reset=1; the pending check never appears.
